// File: rtl/ecall_service_unit.sv
// ecall_service_unit
//
// Services RISC-V ecall instructions using the service number in x17 (a7)
// and the argument in x10 (a0). Sits beside the register file and gives the
// core a halt flag with exit code, a byte-wide console stream, and a
// request/done handshake that holds the core stalled while a service runs.
//
// Services:
//   10 exit        : halt, exit_code = 0
//   93 exit2       : halt, exit_code = x10
//   11 print char  : emit x10[7:0]
//   34 print hex   : emit "0x" + 8 lowercase hex digits of x10 (optional)
//   other          : no-op, completes one cycle after acceptance
//
// Optional feature macro: ECALL_HEX_PRINT_EN
//   defined   -> service 34 streams ten bytes through the console port
//   undefined -> service 34 is a no-op; SEND carries a single byte only
//
// Ports:
//   reset        in   synchronous active-high reset
//   clk          in   single clock, rising edge
//   is_ecall     in   request, held with x17/x10 until ecall_done
//   x17          in   [31:0] service number
//   x10          in   [31:0] argument
//   ecall_done   out  one-cycle completion pulse
//   ecall_stall  out  is_ecall && !ecall_done && !is_halted (combinational)
//   is_halted    out  sticky halt flag
//   exit_code    out  [31:0] exit value, valid when is_halted
//   tx_valid     out  console byte valid
//   tx_data      out  [7:0] console byte
//   tx_ready     in   console sink accepts when tx_valid && tx_ready

module ecall_service_unit (
  input  logic        reset,
  input  logic        clk,
  input  logic        is_ecall,
  input  logic [31:0] x17,
  input  logic [31:0] x10,
  output logic        ecall_done,
  output logic        ecall_stall,
  output logic        is_halted,
  output logic [31:0] exit_code,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam logic [31:0] SVC_EXIT  = 32'd10;
  localparam logic [31:0] SVC_EXIT2 = 32'd93;
  localparam logic [31:0] SVC_PUTC  = 32'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic        is_halted_reg, is_halted_next;
  logic [31:0] exit_code_reg, exit_code_next;
  logic        tx_valid_reg, tx_valid_next;
  logic [7:0]  tx_data_reg, tx_data_next;

  // A new service is only taken while idle and not halted; once halted the
  // unit ignores every further request.
  logic accept;
  logic handshake;

`ifdef ECALL_HEX_PRINT_EN
  localparam logic [31:0] SVC_HEX      = 32'd34;
  localparam logic [3:0]  HEX_LAST_IDX = 4'd9;

  // hex_mode_reg distinguishes a ten-byte hex stream from a single char.
  // The shift register always presents the next nibble to print in [31:28].
  logic        hex_mode_reg, hex_mode_next;
  logic [31:0] hex_shift_reg, hex_shift_next;
  logic [3:0]  byte_idx_reg, byte_idx_next;

  // 0-9 -> '0'-'9', 10-15 -> 'a'-'f'. 0x57 + 10 = 0x61 ('a').
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return {4'h3, nib};
    end else begin
      return 8'h57 + {4'h0, nib};
    end
  endfunction
`endif

  assign accept    = is_ecall && !is_halted_reg;
  assign handshake = tx_valid_reg && tx_ready;

  // Next-state and datapath updates
  always_comb begin
    state_next     = state_reg;
    is_halted_next = is_halted_reg;
    exit_code_next = exit_code_reg;
    tx_valid_next  = tx_valid_reg;
    tx_data_next   = tx_data_reg;
`ifdef ECALL_HEX_PRINT_EN
    hex_mode_next  = hex_mode_reg;
    hex_shift_next = hex_shift_reg;
    byte_idx_next  = byte_idx_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (x17 == SVC_EXIT) begin
            is_halted_next = 1'b1;
            exit_code_next = 32'd0;
            state_next     = DONE;
          end else if (x17 == SVC_EXIT2) begin
            is_halted_next = 1'b1;
            exit_code_next = x10;
            state_next     = DONE;
          end else if (x17 == SVC_PUTC) begin
            tx_valid_next  = 1'b1;
            tx_data_next   = x10[7:0];
`ifdef ECALL_HEX_PRINT_EN
            hex_mode_next  = 1'b0;
`endif
            state_next     = SEND;
`ifdef ECALL_HEX_PRINT_EN
          end else if (x17 == SVC_HEX) begin
            // Argument is captured here; later x10 changes are ignored.
            hex_mode_next  = 1'b1;
            hex_shift_next = x10;
            byte_idx_next  = 4'd0;
            tx_valid_next  = 1'b1;
            tx_data_next   = 8'h30;
            state_next     = SEND;
`endif
          end else begin
            state_next = DONE;
          end
        end
      end

      SEND: begin
        // tx_valid/tx_data only move on a handshake, so they stay stable
        // for as long as the sink holds tx_ready low.
        if (handshake) begin
`ifdef ECALL_HEX_PRINT_EN
          if (hex_mode_reg && (byte_idx_reg != HEX_LAST_IDX)) begin
            byte_idx_next = byte_idx_reg + 4'd1;
            if (byte_idx_reg == 4'd0) begin
              tx_data_next = 8'h78;
            end else begin
              tx_data_next   = hex_ascii(hex_shift_reg[31:28]);
              hex_shift_next = {hex_shift_reg[27:0], 4'h0};
            end
          end else begin
            tx_valid_next = 1'b0;
            state_next    = DONE;
          end
`else
          tx_valid_next = 1'b0;
          state_next    = DONE;
`endif
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      is_halted_reg <= 1'b0;
      exit_code_reg <= 32'd0;
      tx_valid_reg  <= 1'b0;
      tx_data_reg   <= 8'd0;
`ifdef ECALL_HEX_PRINT_EN
      hex_mode_reg  <= 1'b0;
      hex_shift_reg <= 32'd0;
      byte_idx_reg  <= 4'd0;
`endif
    end else begin
      state_reg     <= state_next;
      is_halted_reg <= is_halted_next;
      exit_code_reg <= exit_code_next;
      tx_valid_reg  <= tx_valid_next;
      tx_data_reg   <= tx_data_next;
`ifdef ECALL_HEX_PRINT_EN
      hex_mode_reg  <= hex_mode_next;
      hex_shift_reg <= hex_shift_next;
      byte_idx_reg  <= byte_idx_next;
`endif
    end
  end

  // The done pulse is exactly the single DONE cycle.
  assign ecall_done  = (state_reg == DONE);
  assign ecall_stall = is_ecall && !ecall_done && !is_halted_reg;
  assign is_halted   = is_halted_reg;
  assign exit_code   = exit_code_reg;
  assign tx_valid    = tx_valid_reg;
  assign tx_data     = tx_data_reg;

endmodule

// File: doc/ecall_service_unit.md
# ecall_service_unit

Services RISC-V `ecall` instructions for the single-cycle and pipelined cores, using the service number in x17 (a7) and the argument in x10 (a0). It sits beside the register file and provides:
- the halt flag and exit code for the testbench;
- a byte-wide console stream for character and hex output;
- a request/done handshake that holds the core stalled while a service is in progress.

## Interface
Parameters: none.

Ports:
- reset  input  1  synchronous, active-high; sampled on rising clk
- clk  input  1  single clock; all state updates on rising edge
- is_ecall  input  1  service request; held high (with x17/x10 stable) until ecall_done
- x17  input  32  service number (a7)
- x10  input  32  argument (a0)
- ecall_done  output  1  one-cycle pulse; core may retire the ecall at the following edge
- ecall_stall  output  1  core must stall; = is_ecall && !ecall_done && !is_halted
- is_halted  output  1  sticky halt flag
- exit_code  output  32  exit value, valid when is_halted
- tx_valid  output  1  console byte valid
- tx_data  output  8  console byte, ASCII
- tx_ready  input  1  console sink accepts byte when tx_valid && tx_ready

## Operation
- Services decoded from x17:
  - 10 = exit: halt, exit_code=0.
  - 93 = exit2: halt, exit_code=x10.
  - 11 = print char: emit x10[7:0].
  - 34 = print hex: emit "0x" followed by 8 lowercase hex digits of x10, MSB nibble first (see Configuration).
  - Any other value: no-op.
- FSM states: IDLE, SEND, DONE.
  - **IDLE**
    - Acceptance condition: is_ecall && !is_halted. x17 and x10 are latched at that edge.
    - Exit services: go to DONE; is_halted←1 and exit_code loaded at the same edge.
    - Print char: load tx buffer (1 byte), tx_valid←1, go to SEND.
    - Print hex: load 32-bit shift register and byte index 0, tx_valid←1 with '0', go to SEND.
    - Unknown service: go to DONE.
  - **SEND**
    - Each tx_valid && tx_ready handshake advances to the next byte.
    - After the last byte is accepted: tx_valid←0, go to DONE.
    - tx_data and tx_valid are held stable while tx_ready=0. tx_valid is never withdrawn before acceptance.
  - **DONE**
    - ecall_done=1 for exactly this cycle; next state IDLE unconditionally.
- Hex byte sequence: index 0='0', 1='x', 2..9 = nibble x10[31-4(i-2) -: 4]. Digits 0-9 map to 0x30+n; 10-15 map to 0x61+(n-10).
- Halted behaviour:
  - Once is_halted=1, is_ecall is ignored: no new service, no ecall_done, ecall_stall=0.
  - is_halted and exit_code persist until reset.
- Back-to-back ecalls: is_ecall high in the cycle after DONE is a new request and is accepted from IDLE normally.
- x17/x10 changes after acceptance have no effect. Latched copies are used throughout the service.

## Timing
- Reset values: state=IDLE, ecall_done=0, is_halted=0, exit_code=0, tx_valid=0, tx_data=0.
- Reset mid-service (SEND or DONE): all outputs return to reset values at that edge. The pending byte stream is abandoned.
- With request accepted at edge T (is_ecall seen in cycle T):
  - Exit service: is_halted=1 and ecall_done=1 in cycle T+1.
  - Unknown service: ecall_done=1 in cycle T+1.
  - Print char with tx_ready always 1: tx_valid in T+1, ecall_done in T+2.
  - Print hex with tx_ready always 1: bytes in T+1..T+10, ecall_done in T+11.
  - Each cycle of tx_ready=0 adds one cycle of latency.
- ecall_stall is combinational from is_ecall.

## Configuration
- Macro: ECALL_HEX_PRINT_EN.
- Defined: service 34 is implemented as above.
- Undefined: service 34 is treated as unknown (no-op, ecall_done at T+1). The hex shift register and digit logic are not synthesized, and the SEND path handles single bytes only.

## Test plan
- **Exit:** x17=10, x10=5, is_ecall pulse held.
  - Response: is_halted=1 and ecall_done=1 one cycle later, exit_code=0.
  - A later ecall with x17=11 produces no tx_valid and no ecall_done.
- **Exit2:** x17=93, x10=0xFFFFFFFF.
  - Response: is_halted=1, exit_code=0xFFFFFFFF. Reset then clears both to 0.
- **Print char with backpressure:** x17=11, x10=0x00000141, tx_ready low for 3 cycles then high.
  - Response: tx_data=0x41 stable for 4 cycles. Exactly one byte accepted. ecall_done one cycle after acceptance.
- **Print hex:** x17=34, x10=0x1234ABCD, tx_ready=1.
  - With macro defined: stream "0x1234abcd" (0x30,0x78,0x31,0x32,0x33,0x34,0x61,0x62,0x63,0x64), ecall_done at T+11.
  - Without macro: no bytes, ecall_done at T+1.
- **Unknown service:** x17=7, followed immediately by a back-to-back x17=11 ecall.
  - Response: first ecall_done at T+1. The second request is accepted in the cycle after DONE, and its byte is emitted.
- **Reset mid-hex:** assert reset after 4 bytes accepted.
  - Response: tx_valid=0 and state IDLE the next cycle. No ecall_done. A fresh print-char ecall then works normally.
